fsm_seq_ctrl: RTL and testbench

Command-driven sequencer and error-recovery controller for the one-hot control FSM (inputs `i1`..`i4`, `restart`; outputs `o1`..`o4`, `err`). It accepts a command through a valid/ready handshake, drives the FSM inputs to steer it toward a target state, and checks the FSM's registered outputs against an expected pattern. On FSM error it pulses `restart` and retries; it returns a status through a response handshake.

---
 rtl/fsm_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// Command sequencer and error-recovery controller for the one-hot control FSM.
// Define FSM_SEQ_CTRL_STATS_EN to build the saturating FSM error-event counter.
module fsm_seq_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int RST_CYC   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_drive,
    input  logic [3:0]  cmd_expect,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [2:0]  rsp_retries,
    output logic [3:0]  fsm_i,
    output logic        fsm_restart,
    input  logic [3:0]  fsm_o,
    input  logic        fsm_err,
    output logic [15:0] err_count,
    input  logic        err_count_clr
);
    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_WAIT, S_RESTART, S_SETTLE, S_RESP
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_CYC - 1);
    localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

    state_t     state_q, state_d;
    logic [3:0] drive_q, drive_d;
    logic [3:0] expect_q, expect_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] retry_q, retry_d;
    logic [1:0] status_q, status_d;
    logic [3:0] fsm_i_q, fsm_i_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       restart_q, restart_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        drive_d  = drive_q;
        expect_d = expect_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        status_d = status_q;
        fsm_i_d  = fsm_i_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    drive_d  = cmd_drive;
                    expect_d = cmd_expect;
                    retry_d  = '0;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                fsm_i_d = drive_q;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fsm_err) begin
                    fsm_i_d = '0;
                    timer_d = '0;
                    state_d = S_RESTART;
                end else if (fsm_o == expect_q) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESTART: begin
                // The timer doubles as the restart-pulse length counter.
                if (timer_q == RST_LAST) begin
                    timer_d = '0;
                    state_d = S_SETTLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (!fsm_err && fsm_o == 4'b0000) begin
                    if (retry_q == RETRY_MAX) begin
                        status_d = ST_FAIL;
                        state_d  = S_RESP;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_APPLY;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    status_d = ST_FAIL;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and restart outputs are registered copies of the next state.
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        restart_d   = (state_d == S_RESTART);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= S_IDLE;
            drive_q     <= '0;
            expect_q    <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            status_q    <= ST_OK;
            fsm_i_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drive_q     <= drive_d;
            expect_q    <= expect_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            status_q    <= status_d;
            fsm_i_q     <= fsm_i_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            restart_q   <= restart_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = status_q;
    assign rsp_retries = retry_q;
    assign fsm_i       = fsm_i_q;
    assign fsm_restart = restart_q;

`ifdef FSM_SEQ_CTRL_STATS_EN
    logic        err_prev_q;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_count_clr) begin
            err_count_d = '0;
        end else if (fsm_err && !err_prev_q && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_prev_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_prev_q  <= fsm_err;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_err_count_clr;
    assign unused_err_count_clr = err_count_clr;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl: drives it against a small behavioural model
// of the one-hot control FSM and checks per-cycle rules plus directed transactions.
`timescale 1ns/1ps
module tb_fsm_seq_ctrl;
    localparam int TIMEOUT   = 16;
    localparam int RST_CYC   = 2;
    localparam int MAX_RETRY = 3;
`ifdef FSM_SEQ_CTRL_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_drive = '0;
    logic [3:0]  cmd_expect = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [2:0]  rsp_retries;
    logic [3:0]  fsm_i;
    logic        fsm_restart;
    logic [3:0]  fsm_o;
    logic        fsm_err;
    logic [15:0] err_count;
    logic        err_count_clr = 1'b0;

    always #5 clk = ~clk;

    fsm_seq_ctrl #(.TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_drive(cmd_drive), .cmd_expect(cmd_expect),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_retries(rsp_retries),
        .fsm_i(fsm_i), .fsm_restart(fsm_restart),
        .fsm_o(fsm_o), .fsm_err(fsm_err),
        .err_count(err_count), .err_count_clr(err_count_clr)
    );

    // Controlled FSM: 0011 -> S1 (o=0010), 0001 -> ERROR (err=1, sticky until restart),
    // 0000 -> IDLE. Outputs lag inputs by two cycles.
    typedef enum logic [1:0] {F_IDLE, F_S1, F_ERR} fstate_t;
    fstate_t f_cs;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_cs    <= F_IDLE;
            fsm_o   <= 4'b0000;
            fsm_err <= 1'b0;
        end else begin
            if (fsm_restart) f_cs <= F_IDLE;
            else if (f_cs != F_ERR) begin
                case (fsm_i)
                    4'b0011: f_cs <= F_S1;
                    4'b0001: f_cs <= F_ERR;
                    4'b0000: f_cs <= F_IDLE;
                    default: ;
                endcase
            end
            fsm_o   <= (f_cs == F_S1) ? 4'b0010 : 4'b0000;
            fsm_err <= (f_cs == F_ERR);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Error-event model: rising edges of fsm_err, clear has priority, saturating.
    int   m_err_count;
    logic m_err_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err_count <= 0;
            m_err_prev  <= 1'b0;
        end else begin
            m_err_prev <= fsm_err;
            if (err_count_clr) m_err_count <= 0;
            else if (fsm_err && !m_err_prev) m_err_count <= (m_err_count == 65535) ? 65535 : m_err_count + 1;
        end
    end

    // Per-cycle rule checker, sampled just after each rising edge.
    int         rs_run = 0;
    int         rs_pulses = 0;
    logic       prev_rv = 1'b0;
    logic [1:0] prev_st = '0;
    logic [2:0] prev_rt = '0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            rs_run  = 0;
            prev_rv = 1'b0;
        end else begin
            check("ready_and_valid_exclusive", 32'(cmd_ready & rsp_valid), 0);
            check("err_count_model", 32'(err_count), STATS_EN ? 32'(m_err_count) : 0);
            if (fsm_restart) begin
                check("restart_drives_zero", 32'(fsm_i), 0);
                rs_run++;
            end else if (rs_run != 0) begin
                check("restart_pulse_len", rs_run, RST_CYC);
                rs_pulses++;
                rs_run = 0;
            end
            if (prev_rv && !rsp_ready) begin
                check("rsp_valid_held", 32'(rsp_valid), 1);
                check("rsp_status_held", 32'(rsp_status), 32'(prev_st));
                check("rsp_retries_held", 32'(rsp_retries), 32'(prev_rt));
            end
            prev_rv = rsp_valid;
            prev_st = rsp_status;
            prev_rt = rsp_retries;
        end
    end

    int acc_cyc = 0;

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [3:0] d, input logic [3:0] e);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_drive  = d;
        cmd_expect = e;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_seen", 32'(cmd_ready), 1);
        @(negedge clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_cleared", 32'(rsp_valid), 0);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 1);
    endtask

    initial begin
        int lat;
        int p0;
        int n;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_status", 32'(rsp_status), 0);
        check("rst_rsp_retries", 32'(rsp_retries), 0);
        check("rst_fsm_i", 32'(fsm_i), 0);
        check("rst_fsm_restart", 32'(fsm_restart), 0);
        check("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_release", 32'(cmd_ready), 1);

        // OK: FSM IDLE -> S1, best-case latency 4.
        p0 = rs_pulses;
        send(4'b0011, 4'b0010);
        wait_rsp(lat);
        check("ok_latency", lat, 4);
        check("ok_status", 32'(rsp_status), 0);
        check("ok_retries", 32'(rsp_retries), 0);
        check("ok_fsm_i", 32'(fsm_i), 32'h3);
        consume();
        check("ok_fsm_i_parked", 32'(fsm_i), 32'h3);
        check("ok_no_restart", rs_pulses - p0, 0);

        // TIMEOUT: expect never reached, no error.
        p0 = rs_pulses;
        send(4'b0000, 4'b1000);
        wait_rsp(lat);
        check("to_latency", lat, 17);
        check("to_status", 32'(rsp_status), 1);
        check("to_retries", 32'(rsp_retries), 0);
        check("to_fsm_i", 32'(fsm_i), 0);
        consume();
        check("to_no_restart", rs_pulses - p0, 0);

        // FAIL: every attempt drives the FSM into ERROR.
        p0 = rs_pulses;
        send(4'b0001, 4'b0100);
        wait_rsp(lat);
        check("fail_latency", lat, 28);
        check("fail_status", 32'(rsp_status), 2);
        check("fail_retries", 32'(rsp_retries), 3);
        check("fail_fsm_i", 32'(fsm_i), 0);
        check("fail_err_count", 32'(err_count), STATS_EN ? 4 : 0);
        consume();
        check("fail_restart_pulses", rs_pulses - p0, 4);

        // Response stall with a competing command offered.
        send(4'b0011, 4'b0010);
        wait_rsp(lat);
        check("stall_latency", lat, 4);
        cmd_valid  = 1'b1;
        cmd_drive  = 4'b0001;
        cmd_expect = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_status", 32'(rsp_status), 0);
            check("stall_retries", 32'(rsp_retries), 0);
            check("stall_cmd_ready", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        consume();
        check("stall_cmd_not_taken", 32'(fsm_i), 32'h3);

        // Counter clear coinciding with an error edge.
        p0 = rs_pulses;
        send(4'b0001, 4'b0100);
        n = 0;
        while (!fsm_err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("clr_err_seen", 32'(fsm_err), 1);
        err_count_clr = 1'b1;
        @(negedge clk);
        err_count_clr = 1'b0;
        check("clr_wins", 32'(err_count), 0);
        wait_rsp(lat);
        check("clr_fail_latency", lat, 28);
        check("clr_fail_status", 32'(rsp_status), 2);
        check("clr_err_count", 32'(err_count), STATS_EN ? 3 : 0);
        consume();
        check("clr_restart_pulses", rs_pulses - p0, 4);

        // Reset in the middle of RESTART.
        send(4'b0001, 4'b0100);
        n = 0;
        while (!fsm_restart && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_restart_seen", 32'(fsm_restart), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_restart", 32'(fsm_restart), 0);
        check("async_rst_fsm_i", 32'(fsm_i), 0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 0);
        check("async_rst_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 0);
        check("post_rst_err_count", 32'(err_count), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
